// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives start/a/b; the slave returns diff/bout/busy/done.
interface serial_subtractor_if #(
    parameter int W = 8
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;
    logic         done;

    modport master (output start, a, b, input diff, bout, busy, done);
    modport slave  (input start, a, b, output diff, bout, busy, done);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, one bit per clock, start/busy/done handshake.
module serial_subtractor_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic br_i,
    output logic d_o,
    output logic br_o
);
    assign d_o  = a_i ^ b_i ^ br_i;
    assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);
endmodule

module serial_subtractor #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, res_q, diff_q;
    logic [CW-1:0] cnt_q;
    logic          br_q, bout_q, busy_q, done_q;

    logic          d_d, br_d, accept;
    logic [W-1:0]  res_d;

    serial_subtractor_cell u_cell (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .br_i (br_q),
        .d_o  (d_d),
        .br_o (br_d)
    );

    // New difference bit enters at the MSB; after W shifts bit 0 sits at the LSB.
    assign res_d  = W'({d_d, res_q} >> 1);
    assign accept = bus.start && (state_q == IDLE || state_q == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q     <= bus.a;
                b_q     <= bus.b;
                br_q    <= 1'b0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= RUN;
            end else begin
                case (state_q)
                    RUN: begin
                        a_q   <= a_q >> 1;
                        b_q   <= b_q >> 1;
                        res_q <= res_d;
                        br_q  <= br_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST) begin
                            diff_q  <= res_d;
                            bout_q  <= br_d;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                    DONE:    state_q <= IDLE;
                    IDLE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
